// File: rtl/l23_arb_pkg.sv
// Shared types and helpers for the L2/L3 egress arbiter.
package l23_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'b00,
    ST_GRANT = 2'b01,
    ST_XFER  = 2'b10
  } arb_state_e;

  localparam int MAX_PORTS = 8;

  // Index width for n items; callers keep n >= 2 so the result is never 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/l23_rr_picker.sv
// Combinational request picker: round-robin from ptr by default,
// lowest-index fixed priority when L23_ARB_FIXED_PRIO_EN is defined (no ptr port then).
module l23_rr_picker
  import l23_arb_pkg::*;
#(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0]        req,
`ifndef L23_ARB_FIXED_PRIO_EN
  input  logic [clog2(N_PORTS)-1:0] ptr,
`endif
  output logic                      valid,
  output logic [clog2(N_PORTS)-1:0] idx
);

  localparam int IW = clog2(N_PORTS);

`ifdef L23_ARB_FIXED_PRIO_EN
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req[k]) begin
        valid = 1'b1;
        idx   = IW'(k);
      end
    end
  end
`else
  // Scan downward so the last hit written is the one closest to ptr.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_PORTS]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % N_PORTS);
      end
    end
  end
`endif

endmodule

// File: rtl/l23_egress_arb.sv
// Egress scheduler: grants one buffer via run, then routes its AXI-Stream frame to the output.
// Build option: L23_ARB_FIXED_PRIO_EN selects lowest-index priority instead of round-robin.
module l23_egress_arb
  import l23_arb_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arb_en,
  input  logic [N_PORTS-1:0]              req,
  input  logic [N_PORTS-1:0]              idle,
  output logic [N_PORTS-1:0]              run,
  input  logic [N_PORTS-1:0]              s_tvalid,
  input  logic [N_PORTS-1:0]              s_tlast,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   s_tdata,
  output logic [N_PORTS-1:0]              s_tready,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  input  logic                            m_tready,
  output logic                            busy,
  output logic [clog2(N_PORTS)-1:0]       gnt_idx
);

  localparam int IW = clog2(N_PORTS);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [N_PORTS-1:0]   run_q, run_d;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic [DATA_WIDTH-1:0] slice [N_PORTS];

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_slice
    assign slice[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef L23_ARB_FIXED_PRIO_EN
  l23_rr_picker #(.N_PORTS(N_PORTS)) u_picker (
    .req   (req),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
`else
  logic [IW-1:0] ptr_q, ptr_d;

  l23_rr_picker #(.N_PORTS(N_PORTS)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      gnt_q   <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    run_d   = run_q;
`ifndef L23_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_ARB: begin
        run_d = '0;
        if (arb_en && pick_valid) begin
          gnt_d   = pick_idx;
          run_d   = N_PORTS'(1) << pick_idx;
          state_d = ST_GRANT;
        end
      end
      // Buffer leaving idle means it has committed to a frame; req loss first is an abort.
      ST_GRANT: begin
        if (!idle[gnt_q]) begin
          run_d   = '0;
          state_d = ST_XFER;
        end else if (!req[gnt_q]) begin
          run_d   = '0;
          state_d = ST_ARB;
        end
      end
      ST_XFER: begin
        if (m_tvalid && m_tready && m_tlast) begin
          state_d = ST_ARB;
`ifndef L23_ARB_FIXED_PRIO_EN
          ptr_d   = (gnt_q == IW'(N_PORTS - 1)) ? '0 : gnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_ARB;
        run_d   = '0;
      end
    endcase
  end

  always_comb begin
    m_tdata  = slice[gnt_q];
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q != ST_ARB) begin
      m_tvalid        = s_tvalid[gnt_q];
      m_tlast         = s_tlast[gnt_q];
      s_tready[gnt_q] = m_tready;
    end
  end

  assign run     = run_q;
  assign busy    = (state_q != ST_ARB);
  assign gnt_idx = gnt_q;

endmodule

// File: tb/tb_l23_egress_arb.sv
// Scoreboard bench for l23_egress_arb: buffer read-side models feed frames, a monitor checks egress beats.
module tb_l23_egress_arb;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            arb_en = 1'b1;
  logic            m_tready = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    idle = '1;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tlast = '0;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N-1:0]    run;
  logic [N-1:0]    s_tready;
  logic            m_tvalid;
  logic            m_tlast;
  logic [DW-1:0]   m_tdata;
  logic            busy;
  logic [1:0]      gnt_idx;

  always #5 clk = ~clk;

  l23_egress_arb #(.N_PORTS(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .req      (req),
    .idle     (idle),
    .run      (run),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .m_tready (m_tready),
    .busy     (busy),
    .gnt_idx  (gnt_idx)
  );

  int total = 0;
  int bad   = 0;
  logic [DW:0] sb[$];
  int grants[$];

  int pend[N]    = '{default: 0};
  int flen[N]    = '{default: 1};
  int bst[N]     = '{default: 0};
  int beat[N]    = '{default: 0};
  int fseq[N]    = '{default: 0};
  int exp_seq[N] = '{default: 0};
  bit nostart[N] = '{default: 1'b0};

  function automatic logic [DW-1:0] mk(input int p, input int s, input int b);
    return {16'(p), 16'(s), 32'hC0DE_0000 | 32'(b)};
  endfunction

  task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue frames in the order the arbiter is expected to serve them.
  task automatic push_order(input int n, input int o0, input int o1, input int o2,
                            input int o3, input int len);
    int e[4];
    e = '{o0, o1, o2, o3};
    for (int i = 0; i < n; i++) begin
      flen[e[i]] = len;
      for (int b = 0; b < len; b++)
        sb.push_back({(b == len - 1), mk(e[i], exp_seq[e[i]], b)});
      exp_seq[e[i]]++;
      pend[e[i]]++;
    end
  endtask

  task automatic chk_order(input string nm, input int n, input int o0, input int o1,
                           input int o2, input int o3);
    int e[4];
    e = '{o0, o1, o2, o3};
    chk({nm, "_count"}, 65'(grants.size()), 65'(n));
    for (int i = 0; i < n; i++)
      if (i < grants.size()) chk(nm, 65'(grants[i]), 65'(e[i]));
    grants.delete();
  endtask

  task automatic wait_idle(input string nm, input bit toggle);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < 500) begin
      step();
      if (toggle) m_tready = ~m_tready;
      @(negedge clk);
      n++;
      if (sb.size() == 0 && !busy && req == '0) done = 1'b1;
    end
    if (toggle) begin
      step();
      m_tready = 1'b1;
      @(negedge clk);
    end
    chk(nm, 65'(done), 65'd1);
  endtask

  task automatic wait_run(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (run == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 65'(run != '0), 65'd1);
  endtask

  task automatic wait_mvalid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_tvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 65'(m_tvalid), 65'd1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_run"}, 65'(run), 65'd0);
    chk({nm, "_busy"}, 65'(busy), 65'd0);
    chk({nm, "_mtvalid"}, 65'(m_tvalid), 65'd0);
    chk({nm, "_mtlast"}, 65'(m_tlast), 65'd0);
    chk({nm, "_stready"}, 65'(s_tready), 65'd0);
    chk({nm, "_gnt"}, 65'(gnt_idx), 65'd0);
  endtask

  // Buffer read-side models: idle drops the cycle after run is seen, data follows one cycle later.
  initial begin
    logic [N-1:0] run_s, tr_s;
    logic         rst_s;
    forever begin
      @(negedge clk);
      run_s = run;
      tr_s  = s_tready;
      rst_s = rst;
      @(posedge clk);
      #2;
      for (int p = 0; p < N; p++) begin
        if (rst_s) begin
          bst[p] = 0; pend[p] = 0; beat[p] = 0; fseq[p] = 0;
        end else begin
          case (bst[p])
            0: if (pend[p] > 0 && run_s[p] && !nostart[p]) bst[p] = 1;
            1: begin bst[p] = 2; beat[p] = 0; end
            default: begin
              if (tr_s[p]) begin
                if (beat[p] == flen[p] - 1) begin
                  bst[p] = 0; pend[p]--; fseq[p]++;
                end else begin
                  beat[p]++;
                end
              end
            end
          endcase
        end
        req[p]      = (pend[p] > 0);
        idle[p]     = (bst[p] == 0);
        s_tvalid[p] = (bst[p] == 2);
        s_tlast[p]  = (bst[p] == 2) && (beat[p] == flen[p] - 1);
        s_tdata[p*DW +: DW] = mk(p, fseq[p], beat[p]);
      end
    end
  end

  // Monitor: routing checks every cycle, pops the scoreboard on each accepted beat.
  initial begin
    logic [N-1:0] prev_run;
    logic [N-1:0] exp_tr;
    prev_run = '0;
    forever begin
      @(negedge clk);
      chk("run_onehot0", 65'($onehot0(run)), 65'd1);
      if (run != '0 && prev_run == '0)
        for (int i = 0; i < N; i++) if (run[i]) grants.push_back(i);
      prev_run = run;
      if (busy) begin
        exp_tr = m_tready ? (N'(1) << gnt_idx) : '0;
        chk("s_tready_route", 65'(s_tready), 65'(exp_tr));
      end else begin
        chk("arb_outputs_quiet", 65'({m_tvalid, m_tlast, s_tready}), 65'd0);
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got %0h expected none", m_tdata);
        end else begin
          chk("beat", {m_tlast, m_tdata}, sb.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    int ng;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    step();
    rst = 1'b0;

    // Single request on port 2, 5 beats.
    step();
    push_order(1, 2, 0, 0, 0, 5);
    wait_run("t1_grant_seen");
    chk("t1_run", 65'(run), 65'(4'b0100));
    chk("t1_gnt", 65'(gnt_idx), 65'd2);
    n = 1;
    @(negedge clk);
    while (run == 4'b0100 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("t1_run_cycles", 65'(n), 65'd2);
    wait_idle("t1_done", 1'b0);
    chk_order("t1_order", 1, 2, 0, 0, 0);

    // Port 3 alone: ptr wraps to 0 afterwards.
    step();
    push_order(1, 3, 0, 0, 0, 2);
    wait_idle("t1b_done", 1'b0);
    chk_order("t1b_order", 1, 3, 0, 0, 0);

    // Contention between ports 0 and 3.
    step();
`ifdef L23_ARB_FIXED_PRIO_EN
    push_order(3, 0, 0, 3, 0, 3);
    wait_idle("t2_done", 1'b0);
    chk_order("t2_order", 3, 0, 0, 3, 0);
`else
    push_order(3, 0, 3, 0, 0, 3);
    wait_idle("t2_done", 1'b0);
    chk_order("t2_order", 3, 0, 3, 0, 0);
`endif

    // Backpressure: m_tready toggles through an 8-beat frame on port 1.
    step();
    push_order(1, 1, 0, 0, 0, 8);
    wait_idle("t3_done", 1'b1);
    chk_order("t3_order", 1, 1, 0, 0, 0);

    // arb_en dropped mid-frame: frame finishes, then nothing is granted.
    step();
    push_order(1, 2, 0, 0, 0, 4);
    wait_mvalid("t4_xfer_seen");
    step();
`ifdef L23_ARB_FIXED_PRIO_EN
    push_order(4, 0, 1, 2, 3, 4);
`else
    push_order(4, 3, 0, 1, 2, 4);
`endif
    arb_en = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_frame_done", 65'(busy), 65'd0);
    ng = 0;
    repeat (8) begin
      @(negedge clk);
      if (run != '0 || busy) ng++;
    end
    chk("t4_no_grant", 65'(ng), 65'd0);
    chk_order("t4_first", 1, 2, 0, 0, 0);
    step();
    arb_en = 1'b1;
    wait_idle("t4_done", 1'b0);
`ifdef L23_ARB_FIXED_PRIO_EN
    chk_order("t4_order", 4, 0, 1, 2, 3);
`else
    chk_order("t4_order", 4, 3, 0, 1, 2);
`endif

    // Abort: port 1 drops req while granted and still idle.
    step();
    nostart[1] = 1'b1;
    pend[1] = 1;
    wait_run("t5_grant_seen");
    chk("t5_run", 65'(run), 65'(4'b0010));
    step();
    pend[1] = 0;
    @(negedge clk);
    chk("t5_run_held", 65'(run), 65'(4'b0010));
    @(negedge clk);
    chk("t5_run_drop", 65'(run), 65'd0);
    chk("t5_busy_drop", 65'(busy), 65'd0);
    nostart[1] = 1'b0;
    chk_order("t5_abort", 1, 1, 0, 0, 0);
    // ptr must still be 3: port 0 is served before port 2, including a 1-beat frame.
    step();
    push_order(1, 0, 0, 0, 0, 1);
    push_order(1, 2, 0, 0, 0, 2);
    wait_idle("t5_done", 1'b0);
    chk_order("t5_order", 2, 0, 2, 0, 0);

    // Reset in the middle of a frame.
    step();
    push_order(1, 3, 0, 0, 0, 8);
    wait_mvalid("t6_xfer_seen");
    @(negedge clk);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    for (int p = 0; p < N; p++) exp_seq[p] = 0;
    @(negedge clk);
    chk_reset_vals("t6_rst");
    chk_order("t6_grant", 1, 3, 0, 0, 0);
    step();
    push_order(1, 1, 0, 0, 0, 3);
    wait_idle("t6_recover", 1'b0);
    chk_order("t6_order", 1, 1, 0, 0, 0);

    chk("sb_empty", 65'(sb.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l23_egress_arb.md
# l23_egress_arb

Round-robin egress scheduler that shares one AXI-Stream output between N_PORTS L2/L3 buffer read sides. It grants a port by asserting that buffer's RUN management input. It routes the granted buffer's stream to the shared output until the frame's last beat is accepted, then re-arbitrates. It sits between the per-buffer read FSMs (their greenflag, idle_mgmt and AXI-out) and the single egress port.

## Interface
Parameters:
- N_PORTS, 4: number of buffers arbitrated (2..8).
- DATA_WIDTH, 64: tdata width.

Ports:
- clk  in  1  clock; one clock domain, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- arb_en  in  1  management enable; low blocks new grants.
- req  in  N_PORTS  per-buffer frame-available (buffer greenflag).
- idle  in  N_PORTS  per-buffer idle_mgmt.
- run  out  N_PORTS  per-buffer run_mgmt; one-hot or zero; registered.
- s_tvalid  in  N_PORTS  per-buffer tvalid.
- s_tlast  in  N_PORTS  per-buffer tlast.
- s_tdata  in  N_PORTS*DATA_WIDTH  per-buffer tdata; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tready  out  N_PORTS  per-buffer tready.
- m_tvalid  out  1  egress tvalid.
- m_tlast  out  1  egress tlast.
- m_tdata  out  DATA_WIDTH  egress tdata.
- m_tready  in  1  egress tready.
- busy  out  1  high in GRANT or XFER.
- gnt_idx  out  clog2(N_PORTS)  index of the current or last granted port.

## Operation
- States: ARB, GRANT, XFER. Reset state is ARB.
- ARB:
  - If arb_en is high and req is nonzero, the picker selects the first requesting port at or after ptr, wrapping modulo N_PORTS.
  - Registers gnt_idx = pick and run = onehot(pick). Next state is GRANT.
  - Otherwise the FSM stays in ARB with run = 0.
- GRANT: run[gnt] is held high.
  - If idle[gnt] == 0, the buffer has started a frame. run goes to 0 and the next state is XFER.
  - Else if req[gnt] == 0, the frame is aborted. run goes to 0, the next state is ARB, and ptr is unchanged.
- XFER:
  - A beat is a handshake: m_tvalid && m_tready.
  - On a beat with m_tlast set: next state is ARB and ptr = (gnt_idx + 1) mod N_PORTS.
- Routing in GRANT and XFER:
  - m_tvalid = s_tvalid[gnt]; m_tlast = s_tlast[gnt]; m_tdata = slice gnt.
  - s_tready[gnt] = m_tready.
  - All other s_tready bits are 0.
- In ARB: m_tvalid = 0, m_tlast = 0, s_tready = 0, m_tdata = slice gnt_idx (don't-care).
- arb_en going low never interrupts GRANT or XFER. It only blocks leaving ARB.
- req and idle of non-granted ports are ignored outside ARB.
- ptr width is clog2(N_PORTS). The increment wraps from N_PORTS-1 to 0 for non-power-of-two N_PORTS.

## Timing
- Reset values: state ARB, ptr 0, gnt_idx 0, run 0, busy 0, m_tvalid 0, m_tlast 0, s_tready 0.
- Grant latency: req sampled in ARB at cycle t gives run[g] = 1 at t+1.
- A buffer seeing greenflag && run leaves its IDLE state at t+2. GRANT then observes idle[g] = 0 and run drops at t+3.
- The output path is combinational from the gnt/state registers; it adds no latency to the data path.
- Minimum gap: one ARB cycle between the last beat of one frame and the next grant.
- m_tready low freezes the granted buffer (s_tready low); m_tvalid, m_tlast and m_tdata pass through unchanged.
- Last beat and new req in the same cycle: the req is evaluated in the following ARB cycle.
- rst in GRANT or XFER: return to the reset values next cycle. The upstream buffers are reset by the same rst.

## Configuration
- L23_ARB_FIXED_PRIO_EN defined: the picker ignores ptr and always grants the lowest-index requesting port. ptr is not implemented.
- Undefined (default): round-robin as described above.

## Structure
- Package l23_arb_pkg holds:
  - state encoding constants ST_ARB = 2'b00, ST_GRANT = 2'b01, ST_XFER = 2'b10;
  - the MAX_PORTS = 8 constant;
  - the clog2 helper function.
- Sub-module l23_rr_picker: combinational; inputs req and ptr; outputs valid and idx. It contains the fixed-priority variant under the macro.
- The top module contains the FSM, the ptr/gnt registers and the output mux.

## Test plan
- Single request: req = 4'b0100, buffer model drops idle 2 cycles after run -> run = 4'b0100 for 2 cycles, gnt_idx = 2, a 5-beat frame is routed unchanged, then state returns to ARB with ptr = 3.
- Contention: req = 4'b1001 held, ptr = 0 -> frames are granted in order port 0, port 3, port 0. Never two run bits set at once.
- Backpressure: m_tready toggles 1010… during an 8-beat frame -> s_tready[gnt] mirrors m_tready, no beat is lost or duplicated, and the frame completes only on the accepted tlast.
- arb_en = 0 asserted mid-XFER -> the current frame completes, then there is no grant while req = 4'b1111. arb_en = 1 -> the next port after the last grant is served.
- Abort: req[1] drops in GRANT before idle[1] falls -> run = 0 next cycle, return to ARB, ptr unchanged, no output beats.
- Build with L23_ARB_FIXED_PRIO_EN and req = 4'b1010 held -> port 1 is granted on every arbitration. Also assert rst mid-XFER -> all outputs reach their reset values next cycle.
